// File: rtl/afifo_push_arb_pkg.sv
// Shared definitions for the async-FIFO push-port arbiter.
package afifo_push_arb_pkg;

    // FIFO word width on the slave-to-requester path
    localparam int S_R_DATASIZE  = 8;

    // Default number of producers sharing the push port
    localparam int ARB_NREQ      = 4;

    // Default beat limit before a packet is forcibly released
    localparam int ARB_MAX_BEATS = 16;

    // Arbiter FSM: waiting for a request, or locked onto one owner's packet
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/afifo_push_arb_if.sv
// Requester handshake, FIFO write port and arbiter status, bundled.
// master = producers/FIFO side, slave = the arbiter.
interface afifo_push_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wpush;
    logic [DW-1:0]      wdata;
    logic               wfull;
    logic [IW-1:0]      grant_id;
    logic               busy;
    logic               err_overrun;

    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, wpush, wdata, grant_id, busy, err_overrun
    );

    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, wpush, wdata, grant_id, busy, err_overrun
    );

endinterface

// File: rtl/afifo_push_arb_rr_pick.sv
// Combinational round-robin finder: first set request at or above rr_ptr,
// wrapping past NREQ-1 back to 0.
module afifo_push_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    logic [IW:0] cand;

    // Walk the requesters starting at rr_ptr, keeping the first hit
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!valid && req[cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/afifo_push_arb.sv
// Round-robin, packet-locked arbiter in front of the async FIFO push port.
// One owner at a time; the grant is held until the owner's last beat or
// until MAX_BEATS beats have gone through, and FIFO-full stalls only the owner.
module afifo_push_arb
    import afifo_push_arb_pkg::*;
#(
    parameter int NREQ      = ARB_NREQ,
    parameter int DW        = S_R_DATASIZE,
    parameter int MAX_BEATS = ARB_MAX_BEATS
) (
    input  logic             clk,
    input  logic             rst,
    afifo_push_arb_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BEATS);

    arb_state_e    state;
    arb_state_e    state_next;
    logic [IW-1:0] grant_id;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] beat_cnt;
    logic          err_overrun;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          accept;
    logic          owner_last;
    logic          at_limit;
    logic          release_pkt;

    afifo_push_arb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    assign owner_last  = bus.req_last[grant_id];
    assign at_limit    = (beat_cnt == CW'(MAX_BEATS - 1));
    assign accept      = bus.wpush;
    assign release_pkt = accept && (owner_last || at_limit);

    assign bus.wdata       = bus.req_data[grant_id*DW +: DW];
    assign bus.grant_id    = grant_id;
    assign bus.busy        = (state == BURST);
    assign bus.err_overrun = err_overrun;

    // Next state plus the owner-only handshake; reset masks push and ready
    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        bus.wpush     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (!rst) begin
                    bus.req_ready[grant_id] = ~bus.wfull;
                    bus.wpush = bus.req_valid[grant_id] & ~bus.wfull;
                end
                if (release_pkt) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, grant, round-robin pointer, beat counter and overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_id    <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_next;
            err_overrun <= release_pkt && !owner_last;
            if (state == IDLE && pick_valid) begin
                grant_id <= pick_idx;
            end
            if (release_pkt) begin
                beat_cnt <= '0;
                rr_ptr   <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
            end else if (accept) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_afifo_push_arb.sv
// Directed bench for afifo_push_arb: NREQ=4, DW=8, MAX_BEATS=16.
module tb_afifo_push_arb;

    logic clk;
    logic rst;
    int   checkCount;
    int   errCount;
    int   pushCount;

    afifo_push_arb_if #(.NREQ(4), .DW(8)) bus ();

    afifo_push_arb #(.NREQ(4), .DW(8), .MAX_BEATS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running write-domain clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count beats actually pushed into the FIFO
    always @(posedge clk) begin
        if (bus.wpush) pushCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic setData(input int i, input logic [7:0] v);
        bus.req_data[i*8 +: 8] = v;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last, input logic full);
        bus.req_valid = valid;
        bus.req_last  = last;
        bus.wfull     = full;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        pushCount = 0;
    endtask

    initial begin
        checkCount = 0;
        errCount   = 0;
        pushCount  = 0;
        rst        = 1'b1;
        bus.req_data = 32'h33_22_11_5A;
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Reset state
        tick();
        tick();
        settle();
        checkOutput("rst_busy",  32'(bus.busy),        32'd0);
        checkOutput("rst_wpush", 32'(bus.wpush),       32'd0);
        checkOutput("rst_ready", 32'(bus.req_ready),   32'd0);
        checkOutput("rst_grant", 32'(bus.grant_id),    32'd0);
        checkOutput("rst_err",   32'(bus.err_overrun), 32'd0);
        checkOutput("rst_wdata", 32'(bus.wdata),       32'h5A);
        rst = 1'b0;
        tick();

        // Requester 2 sends A1, A2, A3
        $display("[TB] three-beat packet from requester 2");
        setData(2, 8'hA1);
        applyStimulus(4'b0100, 4'b0000, 1'b0);
        settle();
        checkOutput("t1_idle_wpush", 32'(bus.wpush), 32'd0);
        tick();
        settle();
        checkOutput("t1_grant", 32'(bus.grant_id),  32'd2);
        checkOutput("t1_busy",  32'(bus.busy),      32'd1);
        checkOutput("t1_ready", 32'(bus.req_ready), 32'b0100);
        checkOutput("t1_push0", 32'(bus.wpush),     32'd1);
        checkOutput("t1_data0", 32'(bus.wdata),     32'hA1);
        tick();
        setData(2, 8'hA2);
        settle();
        checkOutput("t1_push1", 32'(bus.wpush), 32'd1);
        checkOutput("t1_data1", 32'(bus.wdata), 32'hA2);
        tick();
        setData(2, 8'hA3);
        applyStimulus(4'b0100, 4'b0100, 1'b0);
        settle();
        checkOutput("t1_push2", 32'(bus.wpush), 32'd1);
        checkOutput("t1_data2", 32'(bus.wdata), 32'hA3);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        settle();
        checkOutput("t1_busy_end", 32'(bus.busy),   32'd0);
        checkOutput("t1_rr_ptr",   32'(dut.rr_ptr), 32'd3);
        checkOutput("t1_pushes",   32'(pushCount),  32'd3);

        // Requesters 0 and 3 together: order 0, 3, then 0 again
        $display("[TB] round-robin between requesters 0 and 3");
        doReset();
        setData(0, 8'h10);
        setData(3, 8'h30);
        applyStimulus(4'b1001, 4'b0000, 1'b0);
        tick();
        settle();
        checkOutput("t2_grant_a", 32'(bus.grant_id), 32'd0);
        checkOutput("t2_data_a",  32'(bus.wdata),    32'h10);
        tick();
        setData(0, 8'h11);
        applyStimulus(4'b1001, 4'b0001, 1'b0);
        settle();
        checkOutput("t2_data_a1", 32'(bus.wdata), 32'h11);
        tick();
        setData(0, 8'h12);
        applyStimulus(4'b1001, 4'b0000, 1'b0);
        settle();
        checkOutput("t2_gap_busy", 32'(bus.busy), 32'd0);
        tick();
        settle();
        checkOutput("t2_grant_b", 32'(bus.grant_id),  32'd3);
        checkOutput("t2_ready_b", 32'(bus.req_ready), 32'b1000);
        checkOutput("t2_data_b",  32'(bus.wdata),     32'h30);
        tick();
        setData(3, 8'h31);
        applyStimulus(4'b1001, 4'b1000, 1'b0);
        settle();
        checkOutput("t2_data_b1", 32'(bus.wdata), 32'h31);
        tick();
        applyStimulus(4'b1001, 4'b0000, 1'b0);
        settle();
        checkOutput("t2_rr_wrap", 32'(dut.rr_ptr), 32'd0);
        tick();
        settle();
        checkOutput("t2_grant_c", 32'(bus.grant_id), 32'd0);
        checkOutput("t2_data_c",  32'(bus.wdata),    32'h12);

        // FIFO full for four cycles inside a 4-beat packet from requester 1
        $display("[TB] wfull stall inside a packet");
        doReset();
        setData(1, 8'h40);
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        tick();
        settle();
        checkOutput("t3_push0", 32'(bus.wpush), 32'd1);
        tick();
        setData(1, 8'h41);
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            settle();
            checkOutput("t3_stall_push",  32'(bus.wpush),     32'd0);
            checkOutput("t3_stall_ready", 32'(bus.req_ready), 32'd0);
            checkOutput("t3_stall_grant", 32'(bus.grant_id),  32'd1);
            tick();
        end
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        settle();
        checkOutput("t3_cnt_held", 32'(dut.beat_cnt), 32'd1);
        checkOutput("t3_push1",    32'(bus.wpush),    32'd1);
        checkOutput("t3_data1",    32'(bus.wdata),    32'h41);
        tick();
        setData(1, 8'h42);
        settle();
        checkOutput("t3_data2", 32'(bus.wdata), 32'h42);
        tick();
        setData(1, 8'h43);
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        settle();
        checkOutput("t3_data3", 32'(bus.wdata), 32'h43);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        settle();
        checkOutput("t3_pushes", 32'(pushCount),   32'd4);
        checkOutput("t3_busy",   32'(bus.busy),    32'd0);
        checkOutput("t3_err",    32'(bus.err_overrun), 32'd0);

        // Requester 1 streams 16 beats without last; requester 3 waits
        $display("[TB] forced release after MAX_BEATS");
        doReset();
        setData(3, 8'h70);
        applyStimulus(4'b1010, 4'b0000, 1'b0);
        tick();
        settle();
        checkOutput("t4_grant", 32'(bus.grant_id), 32'd1);
        for (int i = 0; i < 16; i++) begin
            setData(1, 8'(8'h80 + i));
            settle();
            checkOutput("t4_beat_data", 32'(bus.wdata), 32'(8'h80 + i));
            tick();
        end
        settle();
        checkOutput("t4_pushes",  32'(pushCount),       32'd16);
        checkOutput("t4_busy",    32'(bus.busy),        32'd0);
        checkOutput("t4_err_on",  32'(bus.err_overrun), 32'd1);
        checkOutput("t4_rr_ptr",  32'(dut.rr_ptr),      32'd2);
        tick();
        settle();
        checkOutput("t4_err_off", 32'(bus.err_overrun), 32'd0);
        checkOutput("t4_next",    32'(bus.grant_id),    32'd3);
        checkOutput("t4_busy2",   32'(bus.busy),        32'd1);

        // Reset on the 2nd beat of requester 3's packet
        $display("[TB] reset mid-packet");
        pushCount = 0;
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        settle();
        checkOutput("t5_push0", 32'(bus.wpush), 32'd1);
        tick();
        setData(3, 8'h71);
        rst = 1'b1;
        settle();
        checkOutput("t5_rst_push",  32'(bus.wpush),     32'd0);
        checkOutput("t5_rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        settle();
        checkOutput("t5_busy",   32'(bus.busy),        32'd0);
        checkOutput("t5_grant",  32'(bus.grant_id),    32'd0);
        checkOutput("t5_rr_ptr", 32'(dut.rr_ptr),      32'd0);
        checkOutput("t5_err",    32'(bus.err_overrun), 32'd0);
        checkOutput("t5_pushes", 32'(pushCount),       32'd1);

        // Owner 0 drops valid for 3 cycles while requester 1 waits
        $display("[TB] owner gap with a competing requester");
        doReset();
        setData(0, 8'h90);
        setData(1, 8'hEE);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        tick();
        settle();
        checkOutput("t6_push0", 32'(bus.wpush), 32'd1);
        tick();
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            checkOutput("t6_gap_push",  32'(bus.wpush),     32'd0);
            checkOutput("t6_gap_ready", 32'(bus.req_ready), 32'b0001);
            checkOutput("t6_gap_grant", 32'(bus.grant_id),  32'd0);
            tick();
        end
        setData(0, 8'h91);
        applyStimulus(4'b0011, 4'b0001, 1'b0);
        settle();
        checkOutput("t6_push1", 32'(bus.wpush), 32'd1);
        checkOutput("t6_data1", 32'(bus.wdata), 32'h91);
        tick();
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        settle();
        checkOutput("t6_pushes", 32'(pushCount), 32'd2);
        checkOutput("t6_idle",   32'(bus.busy),  32'd0);
        tick();
        settle();
        checkOutput("t6_next", 32'(bus.grant_id), 32'd1);
        checkOutput("t6_data_next", 32'(bus.wdata), 32'hEE);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
